// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcodes, width default and FSM encoding for the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_sign_fix.sv
// ============================================================================
// Module      : md_sign_fix
// Description : Operand magnitudes on entry; sign correction of the raw
//               product or quotient/remainder on exit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_src,
    input  logic [WIDTH-1:0]   i_tgt,
    input  logic               i_signed,
    output logic [WIDTH-1:0]   o_src_mag,
    output logic [WIDTH-1:0]   o_tgt_mag,
    input  logic [2*WIDTH-1:0] i_res,
    input  logic               i_is_div,
    input  logic               i_neg_q,
    input  logic               i_neg_r,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);

    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        o_src_mag = (i_signed && i_src[WIDTH-1]) ? (~i_src + 1'b1) : i_src;
        o_tgt_mag = (i_signed && i_tgt[WIDTH-1]) ? (~i_tgt + 1'b1) : i_tgt;

        w_prod = i_neg_q ? (~i_res + 1'b1) : i_res;
        if (i_is_div) begin
            // Result layout for divide: remainder in the upper half, quotient in the lower
            o_lo = i_neg_q ? (~i_res[WIDTH-1:0] + 1'b1) : i_res[WIDTH-1:0];
            o_hi = i_neg_r ? (~i_res[2*WIDTH-1:WIDTH] + 1'b1) : i_res[2*WIDTH-1:WIDTH];
        end else begin
            o_lo = w_prod[WIDTH-1:0];
            o_hi = w_prod[2*WIDTH-1:WIDTH];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32-bit multiply/divide with HI/LO registers
//               (shift-add multiply, restoring divide, one bit per cycle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_src,
    input  logic [WIDTH-1:0] data_tgt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);

    md_state_e          r_state_q, r_state_d;
    logic [CW-1:0]      r_cnt_q, r_cnt_d;
    logic [2*WIDTH-1:0] r_acc_q, r_acc_d;
    logic [WIDTH-1:0]   r_opd_q, r_opd_d;
    logic [WIDTH-1:0]   r_src_q, r_src_d;
    logic               r_is_div_q, r_is_div_d;
    logic               r_negq_q, r_negq_d;
    logic               r_negr_q, r_negr_d;
    logic               r_div0_q, r_div0_d;
    logic               r_busy_q, r_busy_d;
    logic               r_done_q, r_done_d;
    logic [WIDTH-1:0]   r_hi_q, r_hi_d;
    logic [WIDTH-1:0]   r_lo_q, r_lo_d;

    logic               w_signed;
    logic [WIDTH-1:0]   w_src_mag, w_tgt_mag;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_trial;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next;

    assign w_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_src     (data_src),
        .i_tgt     (data_tgt),
        .i_signed  (w_signed),
        .o_src_mag (w_src_mag),
        .o_tgt_mag (w_tgt_mag),
        .i_res     (r_acc_q),
        .i_is_div  (r_is_div_q),
        .i_neg_q   (r_negq_q),
        .i_neg_r   (r_negr_q),
        .o_hi      (w_fix_hi),
        .o_lo      (w_fix_lo)
    );

    // One iteration of each datapath; RUN picks the one matching the op
    always_comb begin
        w_sum      = {1'b0, r_acc_q[2*WIDTH-1:WIDTH]} + (r_acc_q[0] ? {1'b0, r_opd_q} : '0);
        w_mul_next = {w_sum, r_acc_q[WIDTH-1:1]};

        w_rem_sh   = r_acc_q[2*WIDTH-1:WIDTH-1];
        w_ge       = (w_rem_sh >= {1'b0, r_opd_q});
        w_trial    = w_rem_sh[WIDTH-1:0] - r_opd_q;
        w_div_next = w_ge ? {w_trial, r_acc_q[WIDTH-2:0], 1'b1}
                          : {r_acc_q[2*WIDTH-2:0], 1'b0};
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_cnt_d    = r_cnt_q;
        r_acc_d    = r_acc_q;
        r_opd_d    = r_opd_q;
        r_src_d    = r_src_q;
        r_is_div_d = r_is_div_q;
        r_negq_d   = r_negq_q;
        r_negr_d   = r_negr_q;
        r_div0_d   = r_div0_q;
        r_busy_d   = r_busy_q;
        r_done_d   = 1'b0;
        r_hi_d     = r_hi_q;
        r_lo_d     = r_lo_q;

        case (r_state_q)
            MD_IDLE: begin
                if (start) begin
                    case (op)
                        MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                            r_state_d  = MD_RUN;
                            r_cnt_d    = '0;
                            r_busy_d   = 1'b1;
                            r_is_div_d = op[1];
                            r_src_d    = data_src;
                            r_negq_d   = w_signed && (data_src[WIDTH-1] ^ data_tgt[WIDTH-1]);
                            r_negr_d   = w_signed && data_src[WIDTH-1];
                            r_div0_d   = op[1] && (data_tgt == '0);
                            if (op[1]) begin
                                r_acc_d = {{WIDTH{1'b0}}, w_src_mag};
                                r_opd_d = w_tgt_mag;
                            end else begin
                                r_acc_d = {{WIDTH{1'b0}}, w_tgt_mag};
                                r_opd_d = w_src_mag;
                            end
                        end
                        MD_OP_MTHI: r_hi_d = data_src;
                        MD_OP_MTLO: r_lo_d = data_src;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                r_acc_d = r_is_div_q ? w_div_next : w_mul_next;
                r_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == CW'(ITER - 1)) begin
                    r_state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                // Divide by zero reports all-ones quotient and the raw dividend
                if (r_div0_q) begin
                    r_hi_d = r_src_q;
                    r_lo_d = '1;
                end else begin
                    r_hi_d = w_fix_hi;
                    r_lo_d = w_fix_lo;
                end
                r_done_d  = 1'b1;
                r_busy_d  = 1'b0;
                r_state_d = MD_IDLE;
            end
            default: r_state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= MD_IDLE;
            r_cnt_q    <= '0;
            r_acc_q    <= '0;
            r_opd_q    <= '0;
            r_src_q    <= '0;
            r_is_div_q <= 1'b0;
            r_negq_q   <= 1'b0;
            r_negr_q   <= 1'b0;
            r_div0_q   <= 1'b0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_hi_q     <= '0;
            r_lo_q     <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_cnt_q    <= r_cnt_d;
            r_acc_q    <= r_acc_d;
            r_opd_q    <= r_opd_d;
            r_src_q    <= r_src_d;
            r_is_div_q <= r_is_div_d;
            r_negq_q   <= r_negq_d;
            r_negr_q   <= r_negr_d;
            r_div0_q   <= r_div0_d;
            r_busy_q   <= r_busy_d;
            r_done_q   <= r_done_d;
            r_hi_q     <= r_hi_d;
            r_lo_q     <= r_lo_d;
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign hi   = r_hi_q;
    assign lo   = r_lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed and random checks of mult_div_unit against a
//               behavioural arithmetic model with a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_src;
    logic [31:0] data_tgt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mult_div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .data_src (data_src),
        .data_tgt (data_tgt),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference {hi,lo} computed with native wide arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] q, m, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            MD_OP_MULT:  r = 64'(sa * sb);
            MD_OP_MULTU: r = {32'd0, a} * {32'd0, b};
            MD_OP_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q  = 64'(sq);
                    m  = 64'(sr);
                    r  = {m[31:0], q[31:0]};
                end
            end
            MD_OP_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_at, input int rst_at, input string tag);
        int          k;
        int          busy_cnt;
        logic        seen;
        logic [63:0] hold;
        logic [63:0] expv;
        hold = {hi, lo};
        if (rst_at < 0) exp_q.push_back(model(o, a, b));
        start    = 1'b1;
        op       = o;
        data_src = a;
        data_tgt = b;
        @(posedge clk); #1;
        start    = 1'b0;
        data_src = $urandom;
        data_tgt = $urandom;
        check({tag, " busy_rise"}, 64'(busy), 64'd1);
        busy_cnt = 1;
        k        = 0;
        while (!done && k < 40) begin
            if (k == inj_at) begin
                start    = 1'b1;
                op       = MD_OP_DIV;
                data_src = 32'd77;
                data_tgt = 32'd5;
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " rst_hilo"}, {hi, lo}, 64'd0);
                check({tag, " rst_busy_done"}, 64'({busy, done}), 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                seen  = 1'b0;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (done) seen = 1'b1;
                end
                check({tag, " rst_no_done"}, 64'(seen), 64'd0);
                check({tag, " rst_hilo_after"}, {hi, lo}, 64'd0);
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            if (busy) busy_cnt++;
            if (k == 16) check({tag, " hold_hilo"}, {hi, lo}, hold);
        end
        check({tag, " latency"}, 64'(k), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
        end else begin
            expv = exp_q.pop_front();
            check({tag, " result"}, {hi, lo}, expv);
        end
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] hold;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        data_src = '0;
        data_tgt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset busy_done", 64'({busy, done}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, "multu_max");
        do_op(MD_OP_MULT,  32'hFFFF_FFFD, 32'd7,         -1, -1, "mult_neg");
        do_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         -1, -1, "div_neg");
        do_op(MD_OP_DIVU,  32'd100,       32'd7,         -1, -1, "divu");
        do_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1, "div_ovf");
        do_op(MD_OP_DIVU,  32'd5,         32'd0,         -1, -1, "divu_zero");
        do_op(MD_OP_DIV,   32'hFFFF_FFF7, 32'd0,         -1, -1, "div_zero");

        start    = 1'b1;
        op       = MD_OP_MTHI;
        data_src = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("mthi hi", 64'(hi), 64'hDEAD_BEEF);
        op       = MD_OP_MTLO;
        data_src = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo hilo", {hi, lo}, 64'hDEAD_BEEF_1234_5678);
        check("mthilo busy_done", 64'({busy, done}), 64'd0);

        hold     = {hi, lo};
        start    = 1'b1;
        op       = 3'd6;
        data_src = 32'hAAAA_5555;
        @(posedge clk); #1;
        start = 1'b0;
        check("reserved busy", 64'(busy), 64'd0);
        check("reserved hilo", {hi, lo}, hold);

        do_op(MD_OP_MULT, 32'd1234, 32'hFFFF_E9D2, 10, -1, "mult_ignore_start");

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            if (i == 1) ra = ra | 32'h8000_0000;
            do_op(rop, ra, rb, -1, -1, "random");
        end

        do_op(MD_OP_DIV, 32'd1000, 32'd3, -1, 20, "div_reset");
        do_op(MD_OP_DIVU, 32'hFFFF_FFFF, 32'd16, -1, -1, "divu_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
